// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : MEM pipeline stage. Waits for data-SRAM responses, aligns loads,
//            drops stale responses after flush. Optional MS_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 156,
    parameter int MS_TO_WS_BUS_WD = 112
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [41:0]                ms_fwd,
    output logic [6:0]                 ms_exc,
    input  logic                       flush,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata
`ifdef MS_PERF_CNT_EN
    ,
    output logic [31:0]                ms_stall_cnt
`endif
);

    localparam logic [6:0] C_OP_WORD  = 7'd0;
    localparam logic [6:0] C_OP_BYTE  = 7'd1;
    localparam logic [6:0] C_OP_BYTEU = 7'd2;
    localparam logic [6:0] C_OP_HALF  = 7'd3;
    localparam logic [6:0] C_OP_HALFU = 7'd4;
    localparam logic [6:0] C_OP_LEFT  = 7'd5;
    localparam logic [6:0] C_OP_RIGHT = 7'd6;

    logic                       ms_valid_q,    ms_valid_d;
    logic                       wait_data_q,   wait_data_d;
    logic                       rbuf_valid_q,  rbuf_valid_d;
    logic [31:0]                rbuf_q,        rbuf_d;
    logic [1:0]                 discard_cnt_q, discard_cnt_d;
    logic [ES_TO_MS_BUS_WD-1:0] bus_q,         bus_d;

    logic [31:0] w_rt_value;
    logic        w_req_new;
    logic [6:0]  w_exc;
    logic [1:0]  w_addr_low2;
    logic [6:0]  w_memop;
    logic [31:0] w_badvaddr;
    logic        w_res_from_mem;
    logic [3:0]  w_gr_we_raw;
    logic [4:0]  w_dest;
    logic [31:0] w_alu_result;
    logic [31:0] w_pc;
    logic        unused_reserved;

    logic        w_ready_go;
    logic        w_discarding;
    logic        w_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_final_result;
    logic [3:0]  w_gr_we;
    logic        w_load_pending;

    assign w_rt_value      = bus_q[155:124];
    assign unused_reserved = bus_q[123];
    assign w_req_new       = es_to_ms_bus[122];
    assign w_exc           = bus_q[121:115];
    assign w_addr_low2     = bus_q[114:113];
    assign w_memop         = bus_q[112:106];
    assign w_badvaddr      = bus_q[105:74];
    assign w_res_from_mem  = bus_q[73];
    assign w_gr_we_raw     = bus_q[72:69];
    assign w_dest          = bus_q[68:64];
    assign w_alu_result    = bus_q[63:32];
    assign w_pc            = bus_q[31:0];

    // Handshake
    assign w_ready_go     = !wait_data_q;
    assign w_discarding   = (discard_cnt_q != 2'd0);
    assign ms_allowin     = (!ms_valid_q || (w_ready_go && ws_allowin)) && !w_discarding;
    assign ms_to_ws_valid = ms_valid_q && w_ready_go && !flush;
    assign w_load         = es_to_ms_valid && ms_allowin && !flush;

    // Next-state for the stage registers
    always_comb begin
        ms_valid_d    = ms_valid_q;
        wait_data_d   = wait_data_q;
        rbuf_valid_d  = rbuf_valid_q;
        rbuf_d        = rbuf_q;
        discard_cnt_d = discard_cnt_q;
        bus_d         = bus_q;

        if (flush) begin
            ms_valid_d  = 1'b0;
            wait_data_d = 1'b0;
            if (data_sram_data_ok && w_discarding) begin
                discard_cnt_d = discard_cnt_q - 2'd1;
            end else if (wait_data_q && !data_sram_data_ok && discard_cnt_q != 2'd3) begin
                // The flushed request still owes a response; it must be swallowed later.
                discard_cnt_d = discard_cnt_q + 2'd1;
            end
        end else begin
            if (data_sram_data_ok && w_discarding) begin
                discard_cnt_d = discard_cnt_q - 2'd1;
            end

            if (w_load) begin
                bus_d        = es_to_ms_bus;
                ms_valid_d   = 1'b1;
                wait_data_d  = w_req_new;
                rbuf_valid_d = 1'b0;
                if (w_req_new && data_sram_data_ok && !w_discarding && !wait_data_q) begin
                    wait_data_d  = 1'b0;
                    rbuf_d       = data_sram_rdata;
                    rbuf_valid_d = 1'b1;
                end
            end else if (wait_data_q && data_sram_data_ok && !w_discarding) begin
                wait_data_d  = 1'b0;
                rbuf_d       = data_sram_rdata;
                rbuf_valid_d = 1'b1;
            end else if (ms_to_ws_valid && ws_allowin) begin
                ms_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q    <= 1'b0;
            wait_data_q   <= 1'b0;
            rbuf_valid_q  <= 1'b0;
            rbuf_q        <= 32'd0;
            discard_cnt_q <= 2'd0;
            bus_q         <= '0;
        end else begin
            ms_valid_q    <= ms_valid_d;
            wait_data_q   <= wait_data_d;
            rbuf_valid_q  <= rbuf_valid_d;
            rbuf_q        <= rbuf_d;
            discard_cnt_q <= discard_cnt_d;
            bus_q         <= bus_d;
        end
    end

    // Load alignment
    assign w_byte = rbuf_q[{w_addr_low2, 3'b000} +: 8];
    assign w_half = rbuf_q[{w_addr_low2[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = rbuf_q;
        case (w_memop)
            C_OP_WORD:  w_load_data = rbuf_q;
            C_OP_BYTE:  w_load_data = {{24{w_byte[7]}}, w_byte};
            C_OP_BYTEU: w_load_data = {24'd0, w_byte};
            C_OP_HALF:  w_load_data = {{16{w_half[15]}}, w_half};
            C_OP_HALFU: w_load_data = {16'd0, w_half};
            C_OP_LEFT: begin
                case (w_addr_low2)
                    2'd0:    w_load_data = {rbuf_q[7:0],  w_rt_value[23:0]};
                    2'd1:    w_load_data = {rbuf_q[15:0], w_rt_value[15:0]};
                    2'd2:    w_load_data = {rbuf_q[23:0], w_rt_value[7:0]};
                    default: w_load_data = rbuf_q;
                endcase
            end
            C_OP_RIGHT: begin
                case (w_addr_low2)
                    2'd0:    w_load_data = rbuf_q;
                    2'd1:    w_load_data = {w_rt_value[31:24], rbuf_q[31:8]};
                    2'd2:    w_load_data = {w_rt_value[31:16], rbuf_q[31:16]};
                    default: w_load_data = {w_rt_value[31:8],  rbuf_q[31:24]};
                endcase
            end
            default: w_load_data = rbuf_q;
        endcase
    end

    always_comb begin
        w_final_result = w_alu_result;
        w_gr_we        = w_gr_we_raw;
        if (w_exc != 7'd0) begin
            w_gr_we = 4'h0;
        end else if (w_res_from_mem) begin
            if (rbuf_valid_q) begin
                w_final_result = w_load_data;
            end
            if (w_memop == C_OP_LEFT || w_memop == C_OP_RIGHT) begin
                w_gr_we = 4'hf;
            end
        end
    end

    assign w_load_pending = ms_valid_q && w_res_from_mem && wait_data_q;

    assign ms_to_ws_bus = {w_exc, w_badvaddr, w_gr_we, w_dest, w_final_result, w_pc};
    assign ms_exc       = ms_valid_q ? w_exc : 7'd0;
    assign ms_fwd       = ms_valid_q ? {w_load_pending, w_gr_we, w_dest, w_final_result} : 42'd0;

`ifdef MS_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Cycles spent waiting on the SRAM, including draining stale responses.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((ms_valid_q && wait_data_q) || w_discarding) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ms_stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Directed self-checking bench for mem_stage.
// Revision : 1.0
// ============================================================================
module tb_mem_stage;

    logic         clk;
    logic         reset;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [155:0] es_to_ms_bus;
    logic         ms_to_ws_valid;
    logic [111:0] ms_to_ws_bus;
    logic [41:0]  ms_fwd;
    logic [6:0]   ms_exc;
    logic         flush;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
`ifdef MS_PERF_CNT_EN
    logic [31:0]  ms_stall_cnt;
`endif

    int n_tests;
    int n_fail;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_fwd            (ms_fwd),
        .ms_exc            (ms_exc),
        .flush             (flush),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
`ifdef MS_PERF_CNT_EN
        ,
        .ms_stall_cnt      (ms_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [155:0] make_bus(
        input logic [31:0] rt, input logic req, input logic [6:0] exc,
        input logic [1:0] a, input logic [6:0] op, input logic rfm,
        input logic [3:0] we, input logic [4:0] dest, input logic [31:0] alu,
        input logic [31:0] pc);
        logic [155:0] b;
        b = '0;
        b[155:124] = rt;
        b[122]     = req;
        b[121:115] = exc;
        b[114:113] = a;
        b[112:106] = op;
        b[105:74]  = alu;
        b[73]      = rfm;
        b[72:69]   = we;
        b[68:64]   = dest;
        b[63:32]   = alu;
        b[31:0]    = pc;
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Loads one instruction, answers it one cycle later, returns what reaches WB.
    task automatic load_and_get(input logic [155:0] bus, input logic [31:0] rdata,
                                output logic [31:0] res, output logic [3:0] we,
                                output logic ok);
        es_to_ms_bus   = bus;
        es_to_ms_valid = 1'b1;
        step();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rdata;
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hDEAD_0000;
        #1;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ms_to_ws_valid) begin
                ok = 1'b1;
                break;
            end
            step();
            #1;
        end
        res = ms_to_ws_bus[63:32];
        we  = ms_to_ws_bus[72:69];
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        n_tests++;
        if (ms_to_ws_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", ms_to_ws_valid);
        end
        n_tests++;
        if (ms_allowin !== 1'b1) begin
            n_fail++; $display("FAIL reset_allowin: got %b expected 1", ms_allowin);
        end
        n_tests++;
        if (ms_fwd !== 42'd0 || ms_exc !== 7'd0) begin
            n_fail++; $display("FAIL reset_fwd_exc: got fwd=%h exc=%h expected 0/0", ms_fwd, ms_exc);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_lw();
        es_to_ms_bus   = make_bus(32'h0, 1'b1, 7'd0, 2'd0, 7'd0, 1'b1, 4'hf, 5'd5, 32'h1000, 32'h0040_0000);
        es_to_ms_valid = 1'b1;
        #1;
        n_tests++;
        if (ms_allowin !== 1'b1) begin
            n_fail++; $display("FAIL lw_allowin: got %b expected 1", ms_allowin);
        end
        step();
        es_to_ms_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (ms_fwd[41] !== 1'b1 || ms_to_ws_valid !== 1'b0) begin
                n_fail++; $display("FAIL lw_pending: got pending=%b valid=%b expected 1/0", ms_fwd[41], ms_to_ws_valid);
            end
            if (i < 2) step();
        end
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8899_AABB;
        #1;
        n_tests++;
        if (ms_to_ws_valid !== 1'b0) begin
            n_fail++; $display("FAIL lw_early_valid: got %b expected 0", ms_to_ws_valid);
        end
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        #1;
        n_tests++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h8899_AABB || ms_to_ws_bus[68:64] !== 5'd5) begin
            n_fail++; $display("FAIL lw_result: got valid=%b res=%h dest=%0d expected 1/8899aabb/5",
                               ms_to_ws_valid, ms_to_ws_bus[63:32], ms_to_ws_bus[68:64]);
        end
        n_tests++;
        if (ms_fwd[41] !== 1'b0 || ms_fwd[40:37] !== 4'hf || ms_fwd[31:0] !== 32'h8899_AABB) begin
            n_fail++; $display("FAIL lw_fwd: got %h expected pending=0 we=f res=8899aabb", ms_fwd);
        end
        step();
        #1;
        n_tests++;
        if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin
            n_fail++; $display("FAIL lw_drain: got valid=%b allowin=%b expected 0/1", ms_to_ws_valid, ms_allowin);
        end
    endtask

    task automatic test_align();
        logic [31:0] res;
        logic [3:0]  we;
        logic        ok;
        load_and_get(make_bus(32'h0, 1'b1, 7'd0, 2'd2, 7'd1, 1'b1, 4'h1, 5'd3, 32'h2002, 32'h10), 32'h12F4_5678, res, we, ok);
        n_tests++;
        if (!ok || res !== 32'hFFFF_FFF4) begin
            n_fail++; $display("FAIL lb: got ok=%b res=%h expected fffffff4", ok, res);
        end
        load_and_get(make_bus(32'h0, 1'b1, 7'd0, 2'd2, 7'd2, 1'b1, 4'h1, 5'd3, 32'h2002, 32'h14), 32'h12F4_5678, res, we, ok);
        n_tests++;
        if (!ok || res !== 32'h0000_00F4) begin
            n_fail++; $display("FAIL lbu: got ok=%b res=%h expected 000000f4", ok, res);
        end
        load_and_get(make_bus(32'h0, 1'b1, 7'd0, 2'd2, 7'd4, 1'b1, 4'h3, 5'd3, 32'h2002, 32'h18), 32'h12F4_5678, res, we, ok);
        n_tests++;
        if (!ok || res !== 32'h0000_12F4) begin
            n_fail++; $display("FAIL lhu: got ok=%b res=%h expected 000012f4", ok, res);
        end
        load_and_get(make_bus(32'h0, 1'b1, 7'd0, 2'd0, 7'd3, 1'b1, 4'h3, 5'd3, 32'h2000, 32'h1C), 32'h1234_8001, res, we, ok);
        n_tests++;
        if (!ok || res !== 32'hFFFF_8001) begin
            n_fail++; $display("FAIL lh: got ok=%b res=%h expected ffff8001", ok, res);
        end
        load_and_get(make_bus(32'h1122_3344, 1'b1, 7'd0, 2'd1, 7'd5, 1'b1, 4'h3, 5'd7, 32'h2001, 32'h20), 32'hAABB_CCDD, res, we, ok);
        n_tests++;
        if (!ok || res !== 32'hCCDD_3344 || we !== 4'hf) begin
            n_fail++; $display("FAIL lwl: got ok=%b res=%h we=%h expected ccdd3344/f", ok, res, we);
        end
        load_and_get(make_bus(32'h1122_3344, 1'b1, 7'd0, 2'd1, 7'd6, 1'b1, 4'h3, 5'd7, 32'h2001, 32'h24), 32'hAABB_CCDD, res, we, ok);
        n_tests++;
        if (!ok || res !== 32'h11AA_BBCC || we !== 4'hf) begin
            n_fail++; $display("FAIL lwr: got ok=%b res=%h we=%h expected 11aabbcc/f", ok, res, we);
        end
    endtask

    task automatic test_backpressure();
        ws_allowin     = 1'b0;
        es_to_ms_bus   = make_bus(32'h0, 1'b1, 7'd0, 2'd0, 7'd0, 1'b1, 4'hf, 5'd9, 32'h3000, 32'h30);
        es_to_ms_valid = 1'b1;
        step();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h5555_5555;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF || ms_allowin !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold: got valid=%b res=%h allowin=%b expected 1/deadbeef/0",
                                   ms_to_ws_valid, ms_to_ws_bus[63:32], ms_allowin);
            end
            step();
        end
        ws_allowin = 1'b1;
        #1;
        n_tests++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF || ms_allowin !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got valid=%b res=%h allowin=%b expected 1/deadbeef/1",
                               ms_to_ws_valid, ms_to_ws_bus[63:32], ms_allowin);
        end
        step();
        #1;
        n_tests++;
        if (ms_to_ws_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain: got %b expected 0", ms_to_ws_valid);
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        logic [3:0]  we;
        logic        ok;
        es_to_ms_bus   = make_bus(32'h0, 1'b1, 7'd0, 2'd0, 7'd0, 1'b1, 4'hf, 5'd4, 32'h4000, 32'h40);
        es_to_ms_valid = 1'b1;
        step();
        es_to_ms_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        es_to_ms_bus   = make_bus(32'h0, 1'b1, 7'd0, 2'd0, 7'd0, 1'b1, 4'hf, 5'd6, 32'h4100, 32'h44);
        es_to_ms_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if (ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b0 || ms_fwd !== 42'd0) begin
                n_fail++; $display("FAIL flush_block: got allowin=%b valid=%b fwd=%h expected 0/0/0",
                                   ms_allowin, ms_to_ws_valid, ms_fwd);
            end
            step();
        end
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_0BAD;
        #1;
        n_tests++;
        if (ms_allowin !== 1'b0) begin
            n_fail++; $display("FAIL flush_stale_cycle: got allowin=%b expected 0", ms_allowin);
        end
        step();
        data_sram_data_ok = 1'b0;
        #1;
        n_tests++;
        if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_recover: got allowin=%b valid=%b expected 1/0", ms_allowin, ms_to_ws_valid);
        end
        load_and_get(make_bus(32'h0, 1'b1, 7'd0, 2'd0, 7'd0, 1'b1, 4'hf, 5'd6, 32'h4100, 32'h48), 32'h0000_0005, res, we, ok);
        n_tests++;
        if (!ok || res !== 32'h0000_0005) begin
            n_fail++; $display("FAIL flush_newload: got ok=%b res=%h expected 00000005", ok, res);
        end
        // Flush coinciding with a load: nothing enters the stage.
        es_to_ms_bus   = make_bus(32'h0, 1'b0, 7'd0, 2'd0, 7'd0, 1'b0, 4'hf, 5'd2, 32'h77, 32'h4C);
        es_to_ms_valid = 1'b1;
        flush          = 1'b1;
        step();
        es_to_ms_valid = 1'b0;
        flush          = 1'b0;
        #1;
        n_tests++;
        if (ms_to_ws_valid !== 1'b0 || ms_fwd !== 42'd0 || ms_allowin !== 1'b1) begin
            n_fail++; $display("FAIL flush_vs_load: got valid=%b fwd=%h allowin=%b expected 0/0/1",
                               ms_to_ws_valid, ms_fwd, ms_allowin);
        end
    endtask

    task automatic test_exception();
        es_to_ms_bus   = make_bus(32'h0, 1'b0, 7'b0001000, 2'd0, 7'd0, 1'b0, 4'hf, 5'd8, 32'h1234, 32'h50);
        es_to_ms_valid = 1'b1;
        step();
        es_to_ms_valid = 1'b0;
        #1;
        n_tests++;
        if (ms_to_ws_valid !== 1'b1 || ms_exc !== 7'b0001000 || ms_to_ws_bus[111:105] !== 7'b0001000) begin
            n_fail++; $display("FAIL exc_valid: got valid=%b exc=%b busexc=%b expected 1/0001000/0001000",
                               ms_to_ws_valid, ms_exc, ms_to_ws_bus[111:105]);
        end
        n_tests++;
        if (ms_to_ws_bus[72:69] !== 4'h0 || ms_fwd[40:37] !== 4'h0) begin
            n_fail++; $display("FAIL exc_grwe: got we=%h fwdwe=%h expected 0/0", ms_to_ws_bus[72:69], ms_fwd[40:37]);
        end
        step();
        #1;
        n_tests++;
        if (ms_exc !== 7'd0 || ms_to_ws_valid !== 1'b0) begin
            n_fail++; $display("FAIL exc_clear: got exc=%b valid=%b expected 0/0", ms_exc, ms_to_ws_valid);
        end
    endtask

    task automatic test_back_to_back();
        es_to_ms_bus   = make_bus(32'h0, 1'b0, 7'd0, 2'd0, 7'd0, 1'b0, 4'hf, 5'd10, 32'hAAAA_0001, 32'h60);
        es_to_ms_valid = 1'b1;
        step();
        es_to_ms_bus   = make_bus(32'h0, 1'b0, 7'd0, 2'd0, 7'd0, 1'b0, 4'hf, 5'd11, 32'hBBBB_0002, 32'h64);
        #1;
        n_tests++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hAAAA_0001 || ms_allowin !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first: got valid=%b res=%h allowin=%b expected 1/aaaa0001/1",
                               ms_to_ws_valid, ms_to_ws_bus[63:32], ms_allowin);
        end
        step();
        es_to_ms_valid = 1'b0;
        #1;
        n_tests++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hBBBB_0002 || ms_to_ws_bus[31:0] !== 32'h64) begin
            n_fail++; $display("FAIL b2b_second: got valid=%b res=%h pc=%h expected 1/bbbb0002/64",
                               ms_to_ws_valid, ms_to_ws_bus[63:32], ms_to_ws_bus[31:0]);
        end
        step();
    endtask

    task automatic test_reset_inflight();
        es_to_ms_bus   = make_bus(32'h0, 1'b1, 7'd0, 2'd0, 7'd0, 1'b1, 4'hf, 5'd12, 32'h5000, 32'h70);
        es_to_ms_valid = 1'b1;
        step();
        es_to_ms_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        n_tests++;
        if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0 || ms_fwd !== 42'd0) begin
            n_fail++; $display("FAIL reset_inflight: got allowin=%b valid=%b fwd=%h expected 1/0/0",
                               ms_allowin, ms_to_ws_valid, ms_fwd);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset             = 1'b0;
        ws_allowin        = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        flush             = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;

        test_reset();
        test_lw();
        test_align();
        test_backpressure();
        test_flush();
        test_exception();
        test_back_to_back();
        test_reset_inflight();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
